mc_chroma_interp_pipe: RTL
==========================

# mc_chroma_interp_pipe

Streaming, parametrised 4-tap HEVC chroma interpolator for the motion-compensation path. It takes one reference row of LANES+3 pixels per handshake and runs the horizontal pass on each row. Three horizontal intermediate rows are held in a sliding buffer for the vertical pass. Each output beat is one row of LANES predicted samples. The block supersedes the fixed 8-bit combinational filter pair: it adds arbitrary bit depth, multi-lane throughput, block sequencing, valid/ready backpressure, and a 14-bit intermediate output mode for bi-prediction.

## Interface
- BIT_DEPTH, 8: sample bit depth, 8..12
- LANES, 4: output samples per row beat, 1..16
- MAX_H_W, 7: width of blk_h
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- start  in  1  one-cycle block start; sampled only when busy=0
- frac_x  in  3  horizontal eighth-pel phase, latched at start
- frac_y  in  3  vertical eighth-pel phase, latched at start
- out_mode  in  1  latched at start; 0 = uni (rounded, clipped to BIT_DEPTH); 1 = 14-bit signed intermediate
- blk_h  in  MAX_H_W  output rows, 1..2^MAX_H_W-1, latched at start
- busy  out  1  high from the cycle after start through the cycle done pulses
- in_valid  in  1  reference row valid
- in_ready  out  1  row accepted when in_valid & in_ready
- in_pel  in  (LANES+3)*BIT_DEPTH  pixels x-1..x+LANES+1; lane 0 in LSBs
- out_valid  out  1  output row valid
- out_ready  in  1  downstream accepts
- out_pel  out  LANES*16  samples, lane 0 in LSBs; uni mode zero-extended, mode 1 sign-extended
- out_last  out  1  high with the final output row
- done  out  1  one-cycle pulse on acceptance of the final output row

## Operation
- Coefficients per phase 0..7: {0,64,0,0}, {-2,58,10,-2}, {-4,54,16,-2}, {-6,46,28,-4}, {-4,36,36,-4}, {-4,28,46,-6}, {-2,16,54,-4}, {-2,10,58,-2}, applied to taps A,B,C,D.
- shift1 = BIT_DEPTH-8, shift3 = 14-BIT_DEPTH.
- The horizontal sum is signed BIT_DEPTH+8 bits; the vertical sum over intermediates is signed 24 bits.
- pred14 is defined per phase:
  - fx=0, fy=0: pixel<<shift3.
  - fx≠0, fy=0: hsum>>shift1.
  - fx=0, fy≠0: vsum over raw pixels >>shift1.
  - Both ≠0: vsum over h-intermediates >>6, where h = hsum>>shift1.
  - All right shifts are arithmetic.
- Output by mode:
  - Uni: clip((pred14 + (1<<(shift3-1)))>>shift3, 0, 2^BIT_DEPTH-1).
  - Mode 1: pred14 unmodified.
- Rows required: blk_h+3 when fy≠0, otherwise blk_h. For fy≠0, output row r uses input rows r..r+3.
- FSM:
  - IDLE: in_ready=0. start → PRIME when fy≠0, else → RUN.
  - PRIME: accepts 3 rows into the row buffer, produces no output, then → RUN.
  - RUN: each accepted row shifts the buffer and emits one output row. After row blk_h is accepted, → LAST.
  - LAST: waits for the final out handshake, pulses done, → IDLE.
- in_ready = (state∈{PRIME,RUN}) & (!out_valid | out_ready).
- A start while busy is ignored. in_valid outside PRIME/RUN is ignored.
- Reset in any state: state→IDLE, counters and row buffer cleared, all outputs 0. A partly received block is discarded.

## Timing
- Reset values: in_ready=0, out_valid=0, out_last=0, done=0, busy=0, out_pel=0.
- Latency: a RUN-state row accepted at cycle t gives out_valid at t+1.
- The output is one register deep. With out_ready held high, throughput is 1 row/cycle.
- out_pel and out_last stay stable while out_valid=1 & out_ready=0.
- An output handshake and a new input acceptance in the same cycle are legal and lossless.
- The earliest start after done is the cycle following done.

## Structure
- Shared defines header mc_chroma_defs holds:
  - the coefficient table function chroma_coef(phase, tap);
  - the shift1/shift3 derivations;
  - the FSM state encodings.
- Sub-module mc_chroma_tap4 is a combinational signed 4-tap MAC with a parametrised input width. It is instanced LANES times per pass (horizontal on pixels, vertical on intermediates).
- The top level holds the FSM, the row counter, the 3-row × LANES intermediate buffer, and the output register.

## Test plan
- BIT_DEPTH=8, flat field 100, fx=3 fy=5, uni, blk_h=4 → 7 rows consumed, 4 rows of all-100, out_last on row 4, done one cycle later handshake-aligned.
- fx=4 fy=0, uni, row pixels A,B,C,D=0,64,64,0 → 72; with 0,255,255,0 → 255 (clip); with 255,0,0,255 → 0 (clip).
- fx=0 fy=0, out_mode=1, flat 100 → every sample 6400. BIT_DEPTH=10 with flat 400 → 6400.
- Random out_ready (50% low) over blk_h=16, random phases → output row sequence matches the golden model with no drops or duplicates, and outputs hold while stalled.
- rst asserted in PRIME after 2 rows → next cycle everything is at reset values. A subsequent start with blk_h=1, fy=0 → 1 row in, 1 row out, done.
- start pulsed while busy → ignored; the current block completes with its original phases.

Source files
------------

// File: rtl/mc_chroma_interp_pipe_pkg.sv
// rtl/mc_chroma_interp_pipe_pkg.sv - shared types, shift derivations and coefficient table for the chroma interpolator
package mc_chroma_interp_pipe_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PRIME = 2'd1,
        ST_RUN   = 2'd2,
        ST_LAST  = 2'd3
    } state_t;

    localparam int INT_W  = 16;
    localparam int VSUM_W = 24;

    function automatic int shift1(input int bit_depth);
        return bit_depth - 8;
    endfunction

    function automatic int shift3(input int bit_depth);
        return 14 - bit_depth;
    endfunction

    // Row packed as {D, C, B, A} so tap 0 (A) sits in the LSBs.
    function automatic logic signed [7:0] chroma_coef(input logic [2:0] phase, input logic [1:0] tap);
        logic [31:0] row;
        case (phase)
            3'd0:    row = {8'sd0,  8'sd0,  8'sd64, 8'sd0};
            3'd1:    row = {-8'sd2, 8'sd10, 8'sd58, -8'sd2};
            3'd2:    row = {-8'sd2, 8'sd16, 8'sd54, -8'sd4};
            3'd3:    row = {-8'sd4, 8'sd28, 8'sd46, -8'sd6};
            3'd4:    row = {-8'sd4, 8'sd36, 8'sd36, -8'sd4};
            3'd5:    row = {-8'sd6, 8'sd46, 8'sd28, -8'sd4};
            3'd6:    row = {-8'sd4, 8'sd54, 8'sd16, -8'sd2};
            default: row = {-8'sd2, 8'sd58, 8'sd10, -8'sd2};
        endcase
        return row[{tap, 3'b000} +: 8];
    endfunction

endpackage

// File: rtl/mc_chroma_tap4.sv
// rtl/mc_chroma_tap4.sv - combinational signed 4-tap multiply-accumulate
module mc_chroma_tap4 #(
    parameter int IN_W  = 9,
    parameter int OUT_W = 16
) (
    input  logic signed [IN_W-1:0]  a,
    input  logic signed [IN_W-1:0]  b,
    input  logic signed [IN_W-1:0]  c,
    input  logic signed [IN_W-1:0]  d,
    input  logic signed [7:0]       ca,
    input  logic signed [7:0]       cb,
    input  logic signed [7:0]       cc,
    input  logic signed [7:0]       cd,
    output logic signed [OUT_W-1:0] y
);
    logic signed [OUT_W-1:0] ax, bx, cx, dx, cax, cbx, ccx, cdx;

    assign ax  = OUT_W'(a);
    assign bx  = OUT_W'(b);
    assign cx  = OUT_W'(c);
    assign dx  = OUT_W'(d);
    assign cax = OUT_W'(ca);
    assign cbx = OUT_W'(cb);
    assign ccx = OUT_W'(cc);
    assign cdx = OUT_W'(cd);
    assign y   = ax * cax + bx * cbx + cx * ccx + dx * cdx;
endmodule

// File: rtl/mc_chroma_interp_pipe.sv
// rtl/mc_chroma_interp_pipe.sv - streaming multi-lane 4-tap chroma interpolator with block sequencing
module mc_chroma_interp_pipe
    import mc_chroma_interp_pipe_pkg::*;
#(
    parameter int BIT_DEPTH = 8,
    parameter int LANES     = 4,
    parameter int MAX_H_W   = 7
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             start,
    input  logic [2:0]                       frac_x,
    input  logic [2:0]                       frac_y,
    input  logic                             out_mode,
    input  logic [MAX_H_W-1:0]               blk_h,
    output logic                             busy,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [(LANES+3)*BIT_DEPTH-1:0]   in_pel,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [LANES*16-1:0]              out_pel,
    output logic                             out_last,
    output logic                             done
);
    localparam int S1     = shift1(BIT_DEPTH);
    localparam int S3     = shift3(BIT_DEPTH);
    localparam int HSUM_W = BIT_DEPTH + 8;
    localparam logic signed [VSUM_W-1:0] PEL_MAX = VSUM_W'((1 << BIT_DEPTH) - 1);
    localparam logic signed [VSUM_W-1:0] RND3    = VSUM_W'(1 << (S3 - 1));

    state_t               state, state_nx;
    logic [2:0]           fx, fy;
    logic                 mode;
    logic [MAX_H_W-1:0]   rows_h, cnt;
    logic signed [INT_W-1:0] row_buf [3][LANES];
    logic signed [INT_W-1:0] cur [LANES];
    logic [LANES*16-1:0]  res;
    logic                 accept, last_row;

    assign in_ready = (state == ST_PRIME || state == ST_RUN) && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;
    assign last_row = (cnt == rows_h - 1'b1);
    assign busy     = (state != ST_IDLE);
    assign done     = (state == ST_LAST) && out_valid && out_ready;

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        logic signed [BIT_DEPTH:0]  p [4];
        logic signed [HSUM_W-1:0]   hsum;
        logic signed [VSUM_W-1:0]   vsum, pred, rnd;
        logic [15:0]                lane_out;

        for (genvar k = 0; k < 4; k++) begin : g_tap
            assign p[k] = {1'b0, in_pel[(i+k)*BIT_DEPTH +: BIT_DEPTH]};
        end

        mc_chroma_tap4 #(.IN_W(BIT_DEPTH + 1), .OUT_W(HSUM_W)) u_hor (
            .a(p[0]), .b(p[1]), .c(p[2]), .d(p[3]),
            .ca(chroma_coef(fx, 2'd0)), .cb(chroma_coef(fx, 2'd1)),
            .cc(chroma_coef(fx, 2'd2)), .cd(chroma_coef(fx, 2'd3)),
            .y(hsum)
        );

        // With no horizontal phase the buffer keeps raw pixels, so the vertical pass applies shift1 itself.
        assign cur[i] = (fx == 3'd0) ? INT_W'(p[1]) : INT_W'(hsum >>> S1);

        mc_chroma_tap4 #(.IN_W(INT_W), .OUT_W(VSUM_W)) u_ver (
            .a(row_buf[0][i]), .b(row_buf[1][i]), .c(row_buf[2][i]), .d(cur[i]),
            .ca(chroma_coef(fy, 2'd0)), .cb(chroma_coef(fy, 2'd1)),
            .cc(chroma_coef(fy, 2'd2)), .cd(chroma_coef(fy, 2'd3)),
            .y(vsum)
        );

        always_comb begin
            if (fy != 3'd0)      pred = (fx == 3'd0) ? (vsum >>> S1) : (vsum >>> 6);
            else if (fx != 3'd0) pred = VSUM_W'(cur[i]);
            else                 pred = VSUM_W'(p[1]) <<< S3;
            rnd = (pred + RND3) >>> S3;
            if (mode)                lane_out = pred[15:0];
            else if (rnd < 0)        lane_out = 16'd0;
            else if (rnd > PEL_MAX)  lane_out = PEL_MAX[15:0];
            else                     lane_out = rnd[15:0];
        end

        assign res[i*16 +: 16] = lane_out;
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE:  if (start) state_nx = (frac_y != 3'd0) ? ST_PRIME : ST_RUN;
            ST_PRIME: if (accept && cnt == MAX_H_W'(2)) state_nx = ST_RUN;
            ST_RUN:   if (accept && last_row) state_nx = ST_LAST;
            ST_LAST:  if (out_valid && out_ready) state_nx = ST_IDLE;
            default:  state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            fx        <= '0;
            fy        <= '0;
            mode      <= 1'b0;
            rows_h    <= '0;
            cnt       <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_pel   <= '0;
            for (int r = 0; r < 3; r++)
                for (int l = 0; l < LANES; l++)
                    row_buf[r][l] <= '0;
        end else begin
            state <= state_nx;
            if (state == ST_IDLE && start) begin
                fx     <= frac_x;
                fy     <= frac_y;
                mode   <= out_mode;
                rows_h <= blk_h;
                cnt    <= '0;
            end
            if (accept) begin
                for (int l = 0; l < LANES; l++) begin
                    row_buf[0][l] <= row_buf[1][l];
                    row_buf[1][l] <= row_buf[2][l];
                    row_buf[2][l] <= cur[l];
                end
                cnt <= (state == ST_PRIME && cnt == MAX_H_W'(2)) ? '0 : cnt + 1'b1;
            end
            if (accept && state == ST_RUN) begin
                out_valid <= 1'b1;
                out_pel   <= res;
                out_last  <= last_row;
            end else if (out_ready) begin
                out_valid <= 1'b0;
                out_last  <= 1'b0;
            end
        end
    end
endmodule
